// File: rtl/image_stream_reader_pkg.sv
// Shared types and frame geometry for the image stream reader.
package image_stream_pkg;

  localparam int DATA_W_C    = 32;
  localparam int IMG_WORDS_C = 8100;
  localparam int IMG_COLS_C  = 90;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [DATA_W_C-1:0] data;
    logic                eol;
    logic                last;
  } pix_beat_t;

endpackage

// File: rtl/image_stream_reader_if.sv
// ROM fetch pair plus valid/ready pixel stream between the reader and its neighbours.
interface image_stream_reader_if
  import image_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_C,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_rd;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_eol;
  logic              pix_last;

  modport master (
    output rom_addr,
    input  rom_rd,
    output pix_data,
    output pix_valid,
    output pix_eol,
    output pix_last,
    input  pix_ready
  );

  modport slave (
    input  rom_addr,
    output rom_rd,
    input  pix_data,
    input  pix_valid,
    input  pix_eol,
    input  pix_last,
    output pix_ready
  );
endinterface

// File: rtl/image_stream_reader_fifo.sv
// Small synchronous FIFO of pixel beats; head is registered, reads as zero when empty.
// Push while full is accepted only when a pop happens in the same cycle; flush empties it.
module stream_fifo
  import image_stream_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush_i,
  input  logic      push_i,
  input  logic      pop_i,
  input  pix_beat_t din_i,
  output pix_beat_t head_o,
  output logic      full_o,
  output logic      empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  pix_beat_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/image_stream_reader.sv
// Walks the image ROM once per start and streams words with row/frame tags; first word valid
// two cycles after start. Fetch stalls while the output FIFO is full and not draining.
module image_stream_reader
  import image_stream_pkg::*;
#(
  parameter int DATA_W     = DATA_W_C,
  parameter int ADDR_W     = 32,
  parameter int IMG_WORDS  = IMG_WORDS_C,
  parameter int IMG_COLS   = IMG_COLS_C,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  image_stream_reader_if.master bus
);
  localparam int IDX_W = $clog2(IMG_WORDS);
  localparam int COL_W = $clog2(IMG_COLS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IMG_WORDS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_COLS - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             push, pop, flush;
  logic             fifo_full, fifo_empty;
  pix_beat_t        beat_in, head;

  assign pop     = !fifo_empty && bus.pix_ready;
  assign beat_in = '{data: bus.rom_rd, eol: (col_q == LAST_COL), last: (idx_q == LAST_IDX)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    col_d   = col_q;
    flush   = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = FETCH;
          idx_d   = '0;
          col_d   = '0;
          flush   = 1'b1;
        end
      end
      FETCH: begin
        push = !fifo_full || pop;
        if (push) begin
          col_d = (col_q == LAST_COL) ? '0 : col_q + 1'b1;
          // The address parks on the final word so it never walks past the image.
          if (idx_q == LAST_IDX) state_d = DRAIN;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      DRAIN:   if (pop && head.last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q == FETCH || state_q == DRAIN)) begin
      state_d = IDLE;
      flush   = 1'b1;
      push    = 1'b0;
    end
  end

  stream_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (bus.pix_ready),
    .din_i   (beat_in),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign busy          = (state_q == FETCH) || (state_q == DRAIN);
  assign done          = (state_q == DONE);
  assign bus.rom_addr  = {{(ADDR_W-IDX_W){1'b0}}, idx_q};
  assign bus.pix_valid = !fifo_empty;
  assign bus.pix_data  = DATA_W'(head.data);
  assign bus.pix_eol   = head.eol;
  assign bus.pix_last  = head.last;
endmodule

// File: tb/tb_image_stream_reader.sv
// Bench for image_stream_reader: ROM model, randomized consumer, beat-order reference model.
module tb_image_stream_reader;
  localparam int WORDS = 8100;
  localparam int COLS  = 90;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy;
  logic done;

  image_stream_reader_if #(.DATA_W(32), .ADDR_W(32)) bus();

  image_stream_reader #(
    .DATA_W(32), .ADDR_W(32), .IMG_WORDS(WORDS), .IMG_COLS(COLS), .FIFO_DEPTH(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] rom_mem [WORDS];
  assign bus.rom_rd = (bus.rom_addr < 32'(WORDS)) ? rom_mem[bus.rom_addr[12:0]] : 32'hDEAD_BEEF;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] obs_data [$];
  bit          obs_eol  [$];
  bit          obs_last [$];
  int first_hs, last_hs, done_cyc;
  bit timed_out, aborted;

  initial bus.pix_ready = 1'b0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: still running at %0t, limit 2000000", $time);
    $fatal;
  end

  task automatic fill_rom(input bit rnd);
    for (int i = 0; i < WORDS; i++) rom_mem[i] = rnd ? $urandom : 32'(i);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Consumer: records every accepted beat; stops at done, at an abort, or when the budget runs out.
  task automatic collect(input int ready_pct, input int abort_at, input bit poke_start, input int budget);
    obs_data.delete(); obs_eol.delete(); obs_last.delete();
    first_hs = -1; last_hs = -1; done_cyc = -1; timed_out = 1'b1; aborted = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      bus.pix_ready = (int'($urandom_range(99)) < ready_pct);
      if (poke_start && cyc == 50) start = 1'b1;
      if (done) begin
        done_cyc  = cyc;
        timed_out = 1'b0;
        if (poke_start) start = 1'b1;
        break;
      end
      if (bus.pix_valid && bus.pix_ready) begin
        obs_data.push_back(bus.pix_data);
        obs_eol.push_back(bus.pix_eol);
        obs_last.push_back(bus.pix_last);
        if (first_hs < 0) first_hs = cyc;
        if (bus.pix_last) last_hs = cyc;
        if (obs_data.size() - 1 == abort_at) begin
          abort     = 1'b1;
          aborted   = 1'b1;
          timed_out = 1'b0;
          break;
        end
      end
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    bus.pix_ready = 1'b0;
  endtask

  // Reference model: beat i carries ROM word i, eol at the end of each row, last only on the final word.
  function automatic int seq_errors(input int n);
    int bad = 0;
    for (int i = 0; i < n && i < obs_data.size(); i++)
      if (obs_data[i] !== rom_mem[i] || obs_eol[i] !== (i % COLS == COLS - 1) ||
          obs_last[i] !== (i == WORDS - 1)) bad++;
    return bad;
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, bus.pix_valid, bus.pix_eol, bus.pix_last} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_flags: got %b required 00000",
               {busy, done, bus.pix_valid, bus.pix_eol, bus.pix_last});
    end
    n_checks++;
    if (bus.pix_data !== 32'h0) begin
      n_errors++; $display("FAIL reset_data: got %h required 0", bus.pix_data);
    end
    n_checks++;
    if (bus.rom_addr !== 32'h0) begin
      n_errors++; $display("FAIL reset_addr: got %0d required 0", bus.rom_addr);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_fetch();
    bit hit = 1'b0;
    int bad;
    fill_rom(1'b0);
    bus.pix_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (bus.rom_addr == 32'd37) hit = 1'b1;
    end
    n_checks++;
    if (hit !== 1'b1) begin n_errors++; $display("FAIL midreset_reach37: got %0d required 1", hit); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, bus.pix_valid} !== 3'b0 || bus.rom_addr !== 32'h0 || bus.pix_data !== 32'h0) begin
      n_errors++;
      $display("FAIL midreset_outputs: busy/done/valid %b addr %0d data %h required 000 0 0",
               {busy, done, bus.pix_valid}, bus.rom_addr, bus.pix_data);
    end
    bus.pix_ready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    pulse_start();
    n_checks++;
    if (busy !== 1'b1 || bus.rom_addr !== 32'h0) begin
      n_errors++; $display("FAIL midreset_restart: busy %b addr %0d required 1 0", busy, bus.rom_addr);
    end
    collect(100, 2, 1'b0, 100);
    bad = seq_errors(3);
    n_checks++;
    if (obs_data.size() != 3 || bad != 0) begin
      n_errors++; $display("FAIL midreset_stream: beats %0d bad %0d required 3 0", obs_data.size(), bad);
    end
  endtask

  task automatic test_full_frame();
    int bad;
    fill_rom(1'b0);
    pulse_start();
    collect(100, -1, 1'b0, 9000);
    n_checks++;
    if (timed_out !== 1'b0) begin n_errors++; $display("FAIL full_timeout: got %0d required 0", timed_out); end
    n_checks++;
    if (obs_data.size() != WORDS) begin
      n_errors++; $display("FAIL full_count: got %0d required %0d", obs_data.size(), WORDS);
    end
    bad = seq_errors(WORDS);
    n_checks++;
    if (bad != 0) begin n_errors++; $display("FAIL full_seq: bad beats %0d required 0", bad); end
    n_checks++;
    if (first_hs != 0 || last_hs - first_hs != WORDS - 1) begin
      n_errors++;
      $display("FAIL full_rate: first %0d span %0d required 0 %0d", first_hs, last_hs - first_hs, WORDS - 1);
    end
    n_checks++;
    if (done_cyc != last_hs + 1) begin
      n_errors++; $display("FAIL full_done_time: got %0d required %0d", done_cyc, last_hs + 1);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); if (done !== 1'b0 || busy !== 1'b0) bad++; end
    n_checks++;
    if (bad != 0) begin n_errors++; $display("FAIL full_after_done: busy/done cycles %0d required 0", bad); end
  endtask

  task automatic test_backpressure();
    int unstable = 0;
    int bad;
    fill_rom(1'b1);
    bus.pix_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.pix_valid && bus.pix_data !== rom_mem[0]) unstable++;
    end
    n_checks++;
    if (bus.rom_addr !== 32'd4) begin n_errors++; $display("FAIL bp_addr: got %0d required 4", bus.rom_addr); end
    n_checks++;
    if (bus.pix_valid !== 1'b1 || bus.pix_data !== rom_mem[0] || unstable != 0) begin
      n_errors++;
      $display("FAIL bp_head: valid %b data %h unstable %0d required 1 %h 0",
               bus.pix_valid, bus.pix_data, unstable, rom_mem[0]);
    end
    collect(100, 20, 1'b0, 100);
    bad = seq_errors(21);
    n_checks++;
    if (obs_data.size() != 21 || bad != 0 || first_hs != 0) begin
      n_errors++;
      $display("FAIL bp_resume: beats %0d bad %0d first %0d required 21 0 0", obs_data.size(), bad, first_hs);
    end
  endtask

  task automatic test_random_ready();
    int bad;
    fill_rom(1'b1);
    pulse_start();
    collect(50, -1, 1'b0, 40000);
    n_checks++;
    if (timed_out !== 1'b0 || obs_data.size() != WORDS) begin
      n_errors++;
      $display("FAIL rand_count: timeout %0d beats %0d required 0 %0d", timed_out, obs_data.size(), WORDS);
    end
    bad = seq_errors(WORDS);
    n_checks++;
    if (bad != 0) begin n_errors++; $display("FAIL rand_seq: bad beats %0d required 0", bad); end
    n_checks++;
    if (done_cyc != last_hs + 1) begin
      n_errors++; $display("FAIL rand_done_time: got %0d required %0d", done_cyc, last_hs + 1);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); if (done !== 1'b0) bad++; end
    n_checks++;
    if (bad != 0) begin n_errors++; $display("FAIL rand_single_done: extra pulses %0d required 0", bad); end
  endtask

  task automatic test_abort();
    int bad;
    fill_rom(1'b1);
    pulse_start();
    collect(70, 500, 1'b0, 3000);
    bad = seq_errors(501);
    n_checks++;
    if (aborted !== 1'b1 || obs_data.size() != 501 || bad != 0) begin
      n_errors++;
      $display("FAIL abort_stream: aborted %0d beats %0d bad %0d required 1 501 0", aborted, obs_data.size(), bad);
    end
    n_checks++;
    if (bus.pix_valid !== 1'b0 || busy !== 1'b0) begin
      n_errors++; $display("FAIL abort_flush: valid %b busy %b required 0 0", bus.pix_valid, busy);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); if (done !== 1'b0 || bus.pix_valid !== 1'b0) bad++; end
    n_checks++;
    if (bad != 0) begin n_errors++; $display("FAIL abort_no_done: bad cycles %0d required 0", bad); end
    pulse_start();
    collect(100, 3, 1'b0, 50);
    bad = seq_errors(4);
    n_checks++;
    if (obs_data.size() != 4 || bad != 0) begin
      n_errors++; $display("FAIL abort_restart: beats %0d bad %0d required 4 0", obs_data.size(), bad);
    end
  endtask

  task automatic test_start_ignored();
    int bad;
    fill_rom(1'b1);
    pulse_start();
    collect(100, -1, 1'b1, 9000);
    bad = seq_errors(WORDS);
    n_checks++;
    if (timed_out !== 1'b0 || obs_data.size() != WORDS || bad != 0) begin
      n_errors++;
      $display("FAIL start_ign_seq: timeout %0d beats %0d bad %0d required 0 %0d 0",
               timed_out, obs_data.size(), bad, WORDS);
    end
    n_checks++;
    if (done_cyc != last_hs + 1) begin
      n_errors++; $display("FAIL start_ign_done: got %0d required %0d", done_cyc, last_hs + 1);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); if (busy !== 1'b0 || done !== 1'b0) bad++; end
    n_checks++;
    if (bad != 0) begin n_errors++; $display("FAIL start_ign_in_done: busy/done cycles %0d required 0", bad); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_fetch();
    test_full_frame();
    test_backpressure();
    test_random_ready();
    test_abort();
    test_start_ignored();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
